// File: rtl/alu_regfile_pipe_if.sv
// Instruction/result bus between the control FSM and the ALU/register-file pipe.
interface alu_regfile_pipe_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16
);
  localparam int AW = $clog2(NREGS);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [AW-1:0]    ra;
  logic [AW-1:0]    rb;
  logic             imm_sel;
  logic [WIDTH-1:0] imm;
  logic             wb_en;
  logic [WIDTH-1:0] result_o;
  logic             result_valid;
  logic [4:0]       flags_o;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output in_valid, op, ra, rb, imm_sel, imm, wb_en, rd_addr,
    input  in_ready, result_o, result_valid, flags_o, rd_data
  );

  modport slave (
    input  in_valid, op, ra, rb, imm_sel, imm, wb_en, rd_addr,
    output in_ready, result_o, result_valid, flags_o, rd_data
  );
endinterface

// File: rtl/alu_regfile_pipe.sv
// Two-stage (execute, writeback) ALU + register file with WB->EX forwarding
// and an iterative shift-add multiplier that stalls the input for WIDTH cycles.
// Flag register layout: {C,L,F,Z,N} = flags_o[4:0].
module alu_regfile_pipe #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16
) (
  input  logic              clk,
  input  logic              Reset,
  alu_regfile_pipe_if.slave bus
);
  localparam int AW  = $clog2(NREGS);
  localparam int CW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDC = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SUBC = 4'd3;
  localparam logic [3:0] OP_CMP  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_MOV  = 4'd8;
  localparam logic [3:0] OP_LSH  = 4'd9;
  localparam logic [3:0] OP_RSH  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  typedef enum logic {RUN, MUL} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] rf [NREGS];

  // writeback stage: res_q is both result_o and the value being written
  logic [WIDTH-1:0] res_q;
  logic             res_vld_q;
  logic             wb_we_q;
  logic [AW-1:0]    wb_addr_q;
  logic [4:0]       flg_q;

  logic [WIDTH-1:0] mul_a, mul_b, mul_acc, mul_acc_nxt;
  logic [CW-1:0]    mul_cnt;
  logic             mul_done;

  logic             accept, fwd_a, fwd_b;
  logic [WIDTH-1:0] opa, opb, rf_b;
  logic [WIDTH-1:0] alu_res;
  logic [4:0]       alu_flg;
  logic             alu_vld;
  logic [WIDTH:0]   ext;

  assign bus.in_ready     = (state == RUN);
  assign bus.result_o     = res_q;
  assign bus.result_valid = res_vld_q;
  assign bus.flags_o      = flg_q;
  // debug port sees the array only; an in-flight write is not visible yet
  assign bus.rd_data      = rf[bus.rd_addr];

  assign accept = bus.in_valid & bus.in_ready;

  // the writeback stage commits at the end of this cycle; bypass it to EX
  assign fwd_a = res_vld_q & wb_we_q & (wb_addr_q == bus.ra);
  assign fwd_b = res_vld_q & wb_we_q & (wb_addr_q == bus.rb);
  assign opa   = fwd_a ? res_q : rf[bus.ra];
  assign rf_b  = fwd_b ? res_q : rf[bus.rb];
  assign opb   = bus.imm_sel ? bus.imm : rf_b;

  assign mul_acc_nxt = mul_acc + (mul_b[0] ? mul_a : '0);
  assign mul_done    = (state == MUL) && (mul_cnt == '0);

  // single-cycle ALU; flags not touched by an op keep their current value
  always_comb begin
    alu_res = '0;
    alu_flg = flg_q;
    alu_vld = 1'b1;
    ext     = '0;
    case (bus.op)
      OP_ADD, OP_ADDC: begin
        ext = {1'b0, opa} + {1'b0, opb} +
              {{WIDTH{1'b0}}, (bus.op == OP_ADDC) & flg_q[4]};
        alu_res    = ext[MSB:0];
        alu_flg[4] = ext[WIDTH];
        alu_flg[2] = (opa[MSB] == opb[MSB]) && (alu_res[MSB] != opa[MSB]);
      end
      OP_SUB, OP_SUBC, OP_CMP: begin
        ext = {1'b0, opa} - {1'b0, opb} -
              {{WIDTH{1'b0}}, (bus.op == OP_SUBC) & ~flg_q[4]};
        alu_res    = ext[MSB:0];
        alu_flg[4] = ext[WIDTH];
        alu_flg[3] = (opa < opb);
        alu_flg[2] = (opa[MSB] != opb[MSB]) && (alu_res[MSB] != opa[MSB]);
      end
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_MOV:  alu_res = opb;
      OP_LSH:  alu_res = opa << opb[3:0];
      OP_RSH:  alu_res = opa >> opb[3:0];
      OP_MUL:  alu_res = '0;
      default: alu_vld = 1'b0;
    endcase
    if (alu_vld) begin
      alu_flg[1] = (alu_res == '0);
      alu_flg[0] = alu_res[MSB];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= RUN;
    else        state <= state_nxt;
  end

  // FSM next state: MUL holds the input off until the last iteration
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (accept && bus.op == OP_MUL) state_nxt = MUL;
      MUL:     if (mul_cnt == '0) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // execute -> writeback registers and multiplier iteration
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      res_q     <= '0;
      res_vld_q <= 1'b0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      flg_q     <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_acc   <= '0;
      mul_cnt   <= '0;
    end else begin
      res_vld_q <= 1'b0;
      if (accept) begin
        wb_addr_q <= bus.ra;
        wb_we_q   <= bus.wb_en & (bus.op != OP_CMP);
        if (bus.op == OP_MUL) begin
          mul_a   <= opa;
          mul_b   <= opb;
          mul_acc <= '0;
          mul_cnt <= CW'(WIDTH - 1);
        end else if (alu_vld) begin
          res_q     <= alu_res;
          res_vld_q <= 1'b1;
          flg_q     <= alu_flg;
        end
      end else if (state == MUL) begin
        mul_acc <= mul_acc_nxt;
        mul_a   <= mul_a << 1;
        mul_b   <= mul_b >> 1;
        mul_cnt <= mul_cnt - CW'(1);
        if (mul_done) begin
          res_q     <= mul_acc_nxt;
          res_vld_q <= 1'b1;
          flg_q[1]  <= (mul_acc_nxt == '0);
          flg_q[0]  <= mul_acc_nxt[MSB];
        end
      end
    end
  end

  // register file: commit the writeback stage
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (res_vld_q && wb_we_q) begin
      rf[wb_addr_q] <= res_q;
    end
  end
endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Bench for alu_regfile_pipe: two instances (16x16 and 8x4) driven with directed
// and random instructions, checked every cycle against a transaction-level model.
module tb_alu_regfile_pipe;
  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  alu_regfile_pipe_if #(.WIDTH(16), .NREGS(16)) b0 ();
  alu_regfile_pipe_if #(.WIDTH(8),  .NREGS(4))  b1 ();

  alu_regfile_pipe #(.WIDTH(16), .NREGS(16)) u0 (.clk(clk), .Reset(Reset), .bus(b0));
  alu_regfile_pipe #(.WIDTH(8),  .NREGS(4))  u1 (.clk(clk), .Reset(Reset), .bus(b1));

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        imm_sel;
    logic [15:0] imm;
    logic        wb_en;
  } ins_t;

  ins_t cur [2];
  int   rda [2];
  ins_t q0 [$];
  ins_t q1 [$];

  assign b0.in_valid = cur[0].valid;
  assign b0.op       = cur[0].op;
  assign b0.ra       = cur[0].ra;
  assign b0.rb       = cur[0].rb;
  assign b0.imm_sel  = cur[0].imm_sel;
  assign b0.imm      = cur[0].imm;
  assign b0.wb_en    = cur[0].wb_en;
  assign b0.rd_addr  = rda[0][3:0];
  assign b1.in_valid = cur[1].valid;
  assign b1.op       = cur[1].op;
  assign b1.ra       = cur[1].ra[1:0];
  assign b1.rb       = cur[1].rb[1:0];
  assign b1.imm_sel  = cur[1].imm_sel;
  assign b1.imm      = cur[1].imm[7:0];
  assign b1.wb_en    = cur[1].wb_en;
  assign b1.rd_addr  = rda[1][1:0];

  logic [15:0] o_res [2];
  logic [15:0] o_rd  [2];
  logic        o_vld [2];
  logic        o_rdy [2];
  logic [4:0]  o_flg [2];
  assign o_res[0] = b0.result_o;
  assign o_res[1] = {8'h00, b1.result_o};
  assign o_rd[0]  = b0.rd_data;
  assign o_rd[1]  = {8'h00, b1.rd_data};
  assign o_vld[0] = b0.result_valid;
  assign o_vld[1] = b1.result_valid;
  assign o_rdy[0] = b0.in_ready;
  assign o_rdy[1] = b1.in_ready;
  assign o_flg[0] = b0.flags_o;
  assign o_flg[1] = b1.flags_o;

  // model: rf_arch is the sequential (program-order) register state,
  // rf_vis is what the array holds after the writeback lands
  longint     rf_arch [2][16];
  longint     rf_vis  [2][16];
  logic [4:0] m_flg   [2];
  bit         e_vld   [2];
  longint     e_res   [2];
  bit         e_rdy   [2];
  int         mul_left[2];
  longint     mul_res [2];
  logic [4:0] mul_flg [2];
  bit         mul_wr  [2];
  int         mul_dst [2];
  bit         pend_we [2];
  int         pend_a  [2];
  longint     pend_d  [2];
  bit         accepted[2];
  bit         rnd_en;
  int         errors = 0;
  int         checks = 0;

  function automatic int wid(int i);  return (i == 0) ? 16 : 8; endfunction
  function automatic int nreg(int i); return (i == 0) ? 16 : 4; endfunction

  function automatic void chk(string name, int i, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t actual=0x%0h required=0x%0h", name, i, $time, act, exp);
    end
  endfunction

  // instruction semantics from plain integer arithmetic
  function automatic void mexec(input int op, input longint a, input longint b,
                                input logic [4:0] fl, input int w,
                                output longint res, output logic [4:0] nfl,
                                output bit v, output bit wr);
    longint m, half, sa, sb, ss, s, cy;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    sa   = (a >= half) ? a - (m + 1) : a;
    sb   = (b >= half) ? b - (m + 1) : b;
    nfl  = fl; v = 1'b1; wr = 1'b1; res = 0;
    case (op)
      0, 1: begin
        cy = (op == 1 && fl[4]) ? 1 : 0;
        s = a + b + cy; res = s & m;
        nfl[4] = (s > m);
        ss = sa + sb + cy;
        nfl[2] = (ss >= half) || (ss < -half);
      end
      2, 3, 4: begin
        cy = (op == 3 && !fl[4]) ? 1 : 0;
        s = a - b - cy; res = s & m;
        nfl[4] = (s < 0);
        nfl[3] = (a < b);
        ss = sa - sb - cy;
        nfl[2] = (ss >= half) || (ss < -half);
        wr = (op != 4);
      end
      5:  res = a & b;
      6:  res = a | b;
      7:  res = a ^ b;
      8:  res = b;
      9:  res = (a << (b % 16)) & m;
      10: res = a >> (b % 16);
      11: res = (a * b) & m;
      default: begin v = 1'b0; wr = 1'b0; end
    endcase
    if (v) begin
      nfl[1] = (res == 0);
      nfl[0] = (res >= half);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 16; r++) begin rf_arch[i][r] = 0; rf_vis[i][r] = 0; end
      m_flg[i] = '0; e_vld[i] = 1'b0; e_res[i] = 0; e_rdy[i] = 1'b1;
      mul_left[i] = 0; pend_we[i] = 1'b0; accepted[i] = 1'b0;
    end
  endfunction

  function automatic void finish_op(int i, longint res, logic [4:0] fl, bit wr, int dst);
    e_vld[i] = 1'b1; e_res[i] = res; m_flg[i] = fl;
    if (wr) begin
      pend_we[i] = 1'b1; pend_a[i] = dst; pend_d[i] = res;
      rf_arch[i][dst] = res;
    end
  endfunction

  // what happens to instance i at one rising edge
  function automatic void model_edge(int i);
    ins_t c; longint m, a, b, res; logic [4:0] fl; bit v, wr; int dst, rbi;
    c = cur[i];
    m = (longint'(1) << wid(i)) - 1;
    accepted[i] = 1'b0; e_vld[i] = 1'b0;
    if (pend_we[i]) rf_vis[i][pend_a[i]] = pend_d[i];
    pend_we[i] = 1'b0;
    if (mul_left[i] > 0) begin
      mul_left[i]--;
      if (mul_left[i] == 0) finish_op(i, mul_res[i], mul_flg[i], mul_wr[i], mul_dst[i]);
    end else if (c.valid) begin
      accepted[i] = 1'b1;
      dst = int'(c.ra) % nreg(i);
      rbi = int'(c.rb) % nreg(i);
      a = rf_arch[i][dst];
      b = c.imm_sel ? (longint'(c.imm) & m) : rf_arch[i][rbi];
      mexec(int'(c.op), a, b, m_flg[i], wid(i), res, fl, v, wr);
      wr = wr & c.wb_en;
      if (c.op == 4'd11) begin
        mul_left[i] = wid(i); mul_res[i] = res; mul_flg[i] = fl;
        mul_wr[i] = wr; mul_dst[i] = dst;
      end else if (v) begin
        finish_op(i, res, fl, wr, dst);
      end
    end
    e_rdy[i] = (mul_left[i] == 0);
  endfunction

  function automatic ins_t mk(int op, int ra, int rb, bit sel, int imm, bit wb);
    ins_t r;
    r.valid = 1'b1; r.op = 4'(op); r.ra = 4'(ra); r.rb = 4'(rb);
    r.imm_sel = sel; r.imm = 16'(imm); r.wb_en = wb;
    return r;
  endfunction

  function automatic ins_t pick(int i);
    ins_t r;
    r = '0;
    if (i == 0 && q0.size() > 0) return q0.pop_front();
    if (i == 1 && q1.size() > 0) return q1.pop_front();
    if (rnd_en && $urandom_range(0, 9) < 8) begin
      r.valid   = 1'b1;
      r.op      = 4'($urandom_range(0, 15));
      r.ra      = 4'($urandom_range(0, nreg(i) - 1));
      r.rb      = 4'($urandom_range(0, nreg(i) - 1));
      r.imm_sel = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       r.imm = 16'hFFFF;
        1:       r.imm = 16'($urandom_range(0, 3));
        default: r.imm = 16'($urandom);
      endcase
      if (i == 1) r.imm = r.imm & 16'h00FF;
      r.wb_en   = ($urandom_range(0, 3) != 0);
    end
    return r;
  endfunction

  function automatic bit busy();
    return (q0.size() != 0) || (q1.size() != 0) || cur[0].valid || cur[1].valid ||
           (mul_left[0] != 0) || (mul_left[1] != 0);
  endfunction

  task automatic step();
    @(posedge clk);
    if (Reset) begin model_edge(0); model_edge(1); end
    #1;
    for (int i = 0; i < 2; i++) begin
      if (accepted[i] || !cur[i].valid) cur[i] = pick(i);
      rda[i] = $urandom_range(0, nreg(i) - 1);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && busy(); k++) step();
    chk("drain_timeout", 0, longint'(busy()), 0);
    repeat (3) step();
  endtask

  // compare process: every cycle, both instances
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("in_ready",     i, longint'(o_rdy[i]), longint'(e_rdy[i]));
      chk("result_valid", i, longint'(o_vld[i]), longint'(e_vld[i]));
      chk("flags_o",      i, longint'(o_flg[i]), longint'(m_flg[i]));
      chk("rd_data",      i, longint'(o_rd[i]),  rf_vis[i][rda[i]]);
      if (e_vld[i]) chk("result_o", i, longint'(o_res[i]), e_res[i]);
    end
  end

  initial begin
    longint res; logic [4:0] fl; bit v, wr;
    Reset = 1'b1; rnd_en = 1'b0;
    cur[0] = '0; cur[1] = '0; rda[0] = 0; rda[1] = 0;
    model_reset();
    #2 Reset = 1'b0;

    // hand-computed pins on the model itself
    mexec(0, 'h7FFF, 1, 5'h00, 16, res, fl, v, wr);
    chk("pin_add_res", 0, res, 'h8000); chk("pin_add_flg", 0, longint'(fl), 'h05);
    mexec(2, 3, 5, 5'h00, 16, res, fl, v, wr);
    chk("pin_sub_res", 0, res, 'hFFFE); chk("pin_sub_flg", 0, longint'(fl), 'h19);
    mexec(4, 5, 5, 5'h19, 16, res, fl, v, wr);
    chk("pin_cmp_flg", 0, longint'(fl), 'h02); chk("pin_cmp_wr", 0, longint'(wr), 0);
    mexec(0, 'hFFFF, 1, 5'h00, 16, res, fl, v, wr);
    chk("pin_carry_flg", 0, longint'(fl), 'h12);
    mexec(1, 0, 0, 5'h12, 16, res, fl, v, wr);
    chk("pin_addc_res", 0, res, 1);
    mexec(3, 5, 2, 5'h00, 16, res, fl, v, wr);
    chk("pin_subc_res", 0, res, 2);
    mexec(11, 'h123, 'h10, 5'h00, 16, res, fl, v, wr);
    chk("pin_mul16", 0, res, 'h1230);
    mexec(11, 'h13, 'h10, 5'h00, 8, res, fl, v, wr);
    chk("pin_mul8", 1, res, 'h30);

    repeat (3) step();
    Reset = 1'b1;

    q0.push_back(mk(8, 1, 0, 1, 'h7FFF, 1)); q0.push_back(mk(0, 1, 0, 1, 1, 1));
    q0.push_back(mk(8, 2, 0, 1, 5, 1));      q0.push_back(mk(0, 2, 2, 0, 0, 1));
    q0.push_back(mk(8, 4, 0, 1, 3, 1));      q0.push_back(mk(2, 4, 0, 1, 5, 1));
    q0.push_back(mk(8, 5, 0, 1, 5, 1));      q0.push_back(mk(4, 5, 5, 0, 0, 1));
    q0.push_back(mk(8, 6, 0, 1, 'hFFFF, 1)); q0.push_back(mk(0, 6, 0, 1, 1, 1));
    q0.push_back(mk(1, 7, 0, 1, 0, 1));
    q0.push_back(mk(8, 8, 0, 1, 5, 1));      q0.push_back(mk(3, 8, 0, 1, 2, 1));
    q0.push_back(mk(8, 9, 0, 1, 'h123, 1));  q0.push_back(mk(11, 9, 0, 1, 'h10, 1));
    q0.push_back(mk(0, 9, 0, 1, 1, 1));      q0.push_back(mk(12, 3, 0, 0, 0, 1));
    q1.push_back(mk(8, 1, 0, 1, 'h13, 1));   q1.push_back(mk(11, 1, 0, 1, 'h10, 1));
    q1.push_back(mk(0, 1, 0, 1, 1, 1));      q1.push_back(mk(8, 2, 0, 1, 'h7F, 1));
    q1.push_back(mk(0, 2, 0, 1, 1, 1));      q1.push_back(mk(2, 3, 0, 1, 1, 1));
    drain();

    chk("seq_r1", 0, rf_arch[0][1], 'h8000);
    chk("seq_r2", 0, rf_arch[0][2], 'h000A);
    chk("seq_r4", 0, rf_arch[0][4], 'hFFFE);
    chk("seq_r5", 0, rf_arch[0][5], 'h0005);
    chk("seq_r7", 0, rf_arch[0][7], 'h0001);
    chk("seq_r8", 0, rf_arch[0][8], 'h0002);
    chk("seq_r9", 0, rf_arch[0][9], 'h1231);
    chk("seq8_r1", 1, rf_arch[1][1], 'h31);
    chk("seq8_r2", 1, rf_arch[1][2], 'h80);
    chk("seq8_r3", 1, rf_arch[1][3], 'hFF);

    rnd_en = 1'b1;
    repeat (1500) step();
    rnd_en = 1'b0;
    drain();

    // reset in the middle of a multiply
    q0.push_back(mk(11, 1, 2, 0, 0, 1));
    q1.push_back(mk(11, 1, 2, 0, 0, 1));
    for (int k = 0; k < 40 && mul_left[0] == 0; k++) step();
    chk("mul_started", 0, longint'(mul_left[0] != 0), 1);
    repeat (4) step();
    Reset = 1'b0;
    model_reset();
    cur[0] = '0; cur[1] = '0;
    repeat (2) step();
    Reset = 1'b1;
    repeat (24) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
